// File: rtl/core_run_ctrl_pkg.sv
// Shared encodings for the core run controller: FSM states, halt causes
// and the default halt instruction encoding.
package core_run_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_PAUSED = 3'd4
    } run_state_t;

    typedef enum logic [2:0] {
        HC_NONE  = 3'd0,
        HC_STOP  = 3'd1,
        HC_BKPT  = 3'd2,
        HC_HLT   = 3'd3,
        HC_LIMIT = 3'd4,
        HC_STEP  = 3'd5
    } halt_cause_t;

    localparam logic [31:0] HALT_INSN_DEFAULT = 32'hD4400000;

endpackage

// File: rtl/core_run_ctrl_if.sv
// Host/debug controls, datapath observation and run-control outputs of the
// core run controller, bundled as one interface.
interface core_run_ctrl_if;

    // host / debug controls
    logic        start;
    logic        stop;
    logic        step;
    logic        resume;
    logic        bp_en;
    logic [63:0] bp_addr;
    // datapath observation
    logic [63:0] ins_Addr;
    logic [31:0] ins;
    // run-control outputs
    logic        core_rst;
    logic        core_ce;
    logic [2:0]  state;
    logic [2:0]  halt_cause;
    logic [31:0] retired;

    modport master (
        output start, stop, step, resume, bp_en, bp_addr, ins_Addr, ins,
        input  core_rst, core_ce, state, halt_cause, retired
    );

    modport slave (
        input  start, stop, step, resume, bp_en, bp_addr, ins_Addr, ins,
        output core_rst, core_ce, state, halt_cause, retired
    );

endinterface

// File: rtl/core_halt_detect.sv
// Combinational halt evaluation for free-run: stop, halt instruction,
// breakpoint and retire limit, in that priority order.
module core_halt_detect
    import core_run_ctrl_pkg::*;
#(
    parameter logic [31:0] HALT_INSN  = HALT_INSN_DEFAULT,
    parameter int unsigned MAX_CYCLES = 0
) (
    input  logic        stop,
    input  logic [31:0] ins,
    input  logic [63:0] ins_addr,
    input  logic        bp_en,
    input  logic [63:0] bp_addr,
    input  logic        skip_bp,
    input  logic [31:0] retired,
    output logic        halt,
    output halt_cause_t cause
);

    // Highest-priority active condition wins.
    always_comb begin
        halt  = 1'b0;
        cause = HC_NONE;
        if (stop) begin
            halt  = 1'b1;
            cause = HC_STOP;
        end else if (ins == HALT_INSN) begin
            halt  = 1'b1;
            cause = HC_HLT;
        end else if (bp_en && (ins_addr == bp_addr) && !skip_bp) begin
            halt  = 1'b1;
            cause = HC_BKPT;
        end else if ((MAX_CYCLES != 0) && (retired == MAX_CYCLES)) begin
            halt  = 1'b1;
            cause = HC_LIMIT;
        end
    end

endmodule

// File: rtl/core_run_ctrl.sv
// Run controller for the single-cycle datapath: sequences reset, free-run,
// single-step and pause, and gates all architectural updates via core_ce.
module core_run_ctrl
    import core_run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYCLES = 4,
    parameter int unsigned MAX_CYCLES = 0,
    parameter logic [31:0] HALT_INSN  = HALT_INSN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    core_run_ctrl_if.slave  bus
);

    localparam int unsigned CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    run_state_t   state_q, state_d;
    halt_cause_t  cause_q, cause_d;
    logic [31:0]  retired_q, retired_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic         skip_bp_q, skip_bp_d;
    logic         core_rst_q, core_rst_d;
    logic         core_ce;
    logic         halt;
    halt_cause_t  halt_cause;

    core_halt_detect #(
        .HALT_INSN  (HALT_INSN),
        .MAX_CYCLES (MAX_CYCLES)
    ) u_halt_detect (
        .stop     (bus.stop),
        .ins      (bus.ins),
        .ins_addr (bus.ins_Addr),
        .bp_en    (bus.bp_en),
        .bp_addr  (bus.bp_addr),
        .skip_bp  (skip_bp_q),
        .retired  (retired_q),
        .halt     (halt),
        .cause    (halt_cause)
    );

    // Clock-enable, retire counting and next-state selection; start overrides all.
    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        retired_d = retired_q;
        cnt_d     = cnt_q;
        skip_bp_d = 1'b0;
        core_ce   = 1'b0;

        case (state_q)
            ST_RUN:  core_ce = !halt;
            ST_STEP: core_ce = (bus.ins != HALT_INSN);
            default: core_ce = 1'b0;
        endcase
        if (bus.start) begin
            core_ce = 1'b0;
        end

        if (core_ce && (retired_q != '1)) begin
            retired_d = retired_q + 32'd1;
        end

        if (bus.start) begin
            state_d   = ST_RESET;
            cnt_d     = CW'(RST_CYCLES - 1);
            retired_d = '0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                        cause_d = HC_NONE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (halt) begin
                        state_d = ST_PAUSED;
                        cause_d = halt_cause;
                    end
                end
                ST_STEP: begin
                    state_d = ST_PAUSED;
                    cause_d = (bus.ins == HALT_INSN) ? HC_HLT : HC_STEP;
                end
                ST_PAUSED: begin
                    // skip_bp only lives for the first cycle after leaving pause
                    if (bus.step) begin
                        state_d   = ST_STEP;
                        skip_bp_d = 1'b1;
                    end else if (bus.resume) begin
                        state_d   = ST_RUN;
                        skip_bp_d = 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        core_rst_d = (state_d == ST_IDLE) || (state_d == ST_RESET);
    end

    // State, counters and registered core reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cause_q    <= HC_NONE;
            retired_q  <= '0;
            cnt_q      <= '0;
            skip_bp_q  <= 1'b0;
            core_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cause_q    <= cause_d;
            retired_q  <= retired_d;
            cnt_q      <= cnt_d;
            skip_bp_q  <= skip_bp_d;
            core_rst_q <= core_rst_d;
        end
    end

    assign bus.core_ce    = core_ce;
    assign bus.core_rst   = core_rst_q;
    assign bus.state      = state_q;
    assign bus.halt_cause = cause_q;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: a tiny looping program stands in for the datapath,
// a behavioural model is checked every cycle, and directed scenarios pin it.
module tb_core_run_ctrl;

    localparam int unsigned RSTC = 4;
    localparam int unsigned MAXC = 5;
    localparam logic [31:0] HLT  = 32'hD4400000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_run_ctrl_if bus();

    core_run_ctrl #(
        .RST_CYCLES (RSTC),
        .MAX_CYCLES (MAXC),
        .HALT_INSN  (HLT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- bench datapath: 16-word loop program ----------------
    logic [63:0] pc = 64'd0;
    logic [31:0] imem [16];
    int          halt_slot = -1;

    initial begin
        for (int i = 0; i < 16; i++) imem[i] = 32'h8B000000 + 32'(i);
    end

    always @(posedge clk) begin
        if (bus.core_rst)     pc <= 64'd0;
        else if (bus.core_ce) pc <= (pc == 64'h3C) ? 64'd0 : pc + 64'd4;
    end

    assign bus.ins_Addr = pc;
    assign bus.ins      = (halt_slot == int'(pc[5:2])) ? HLT : imem[pc[5:2]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_state = 0;   // 0 idle,1 reset,2 run,3 step,4 paused
    int          m_cause = 0;
    int          m_left  = 0;   // reset cycles still to spend after this one
    logic [31:0] m_ret   = '0;
    bit          m_skip  = 1'b0;
    bit          m_valid = 1'b0;

    function automatic int run_reason();
        if (bus.stop) return 1;
        if (bus.ins == HLT) return 3;
        if (bus.bp_en && bus.ins_Addr == bus.bp_addr && !m_skip) return 2;
        if (MAXC != 0 && m_ret == MAXC) return 4;
        return 0;
    endfunction

    function automatic bit model_ce();
        if (bus.start) return 1'b0;
        if (m_state == 2) return run_reason() == 0;
        if (m_state == 3) return bus.ins != HLT;
        return 1'b0;
    endfunction

    initial begin : model_compare
        bit ce;
        int r;
        forever begin
            @(negedge clk);
            ce = model_ce();
            if (m_valid) begin
                chk("state",      64'(bus.state),      64'(m_state));
                chk("halt_cause", 64'(bus.halt_cause), 64'(m_cause));
                chk("retired",    64'(bus.retired),    64'(m_ret));
                chk("core_rst",   64'(bus.core_rst),   64'(m_state <= 1));
                chk("core_ce",    64'(bus.core_ce),    64'(ce));
            end
            if (rst) begin
                m_state = 0; m_cause = 0; m_ret = '0; m_skip = 1'b0; m_left = 0;
                m_valid = 1'b1;
            end else if (m_valid) begin
                r = run_reason();
                if (ce && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
                if (bus.start) begin
                    m_state = 1; m_left = RSTC - 1; m_ret = '0; m_skip = 1'b0;
                end else if (m_state == 1) begin
                    if (m_left == 0) begin m_state = 2; m_cause = 0; end
                    else m_left--;
                end else if (m_state == 2) begin
                    m_skip = 1'b0;
                    if (r != 0) begin m_state = 4; m_cause = r; end
                end else if (m_state == 3) begin
                    m_skip  = 1'b0;
                    m_state = 4;
                    m_cause = (bus.ins == HLT) ? 3 : 5;
                end else if (m_state == 4) begin
                    if (bus.step)        begin m_state = 3; m_skip = 1'b1; end
                    else if (bus.resume) begin m_state = 2; m_skip = 1'b1; end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input int s, input int budget, input string nm);
        int n = 0;
        while (bus.state !== 3'(s) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (bus.state !== 3'(s)) begin
            errors++;
            $display("FAIL %s: timeout, state %0d expected %0d", nm, bus.state, s);
        end
    endtask

    initial begin : stim
        int n;
        bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.resume = 1'b0;
        bus.bp_en = 1'b1; bus.bp_addr = 64'h10;

        rst = 1'b1;
        repeat (3) tick();
        chk("rst_state",    64'(bus.state),      64'd0);
        chk("rst_core_rst", 64'(bus.core_rst),   64'd1);
        chk("rst_core_ce",  64'(bus.core_ce),    64'd0);
        chk("rst_cause",    64'(bus.halt_cause), 64'd0);
        chk("rst_retired",  64'(bus.retired),    64'd0);
        rst = 1'b0;
        tick();

        // start: exactly RSTC reset cycles, then run
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("start_state", 64'(bus.state), 64'd1);
        n = 0;
        while (bus.core_rst && n < 20) begin n++; tick(); end
        chk("rst_cycles", 64'(n), 64'd4);
        chk("run_state", 64'(bus.state), 64'd2);
        chk("run_ce",    64'(bus.core_ce), 64'd1);
        tick(); chk("retired_1", 64'(bus.retired), 64'd1);
        tick(); chk("retired_2", 64'(bus.retired), 64'd2);

        // breakpoint at 0x10
        wait_state(4, 20, "bp_wait");
        chk("bp_cause",   64'(bus.halt_cause), 64'd2);
        chk("bp_pc",      pc,                  64'h10);
        chk("bp_retired", 64'(bus.retired),    64'd4);

        // resume off the breakpoint, then cycle limit at 5
        bus.resume = 1'b1; tick(); bus.resume = 1'b0;
        wait_state(4, 20, "lim_wait");
        chk("lim_cause",   64'(bus.halt_cause), 64'd4);
        chk("lim_retired", 64'(bus.retired),    64'd5);
        chk("lim_pc",      pc,                  64'h14);

        // single step
        bus.step = 1'b1; tick(); bus.step = 1'b0;
        chk("step_state", 64'(bus.state), 64'd3);
        tick();
        chk("step_done",    64'(bus.state),      64'd4);
        chk("step_cause",   64'(bus.halt_cause), 64'd5);
        chk("step_retired", 64'(bus.retired),    64'd6);

        // loop around to revisit the breakpoint
        bus.resume = 1'b1; tick(); bus.resume = 1'b0;
        wait_state(4, 40, "rebp_wait");
        chk("rebp_cause",   64'(bus.halt_cause), 64'd2);
        chk("rebp_retired", 64'(bus.retired),    64'd20);

        // halt instruction at 0x18; stepping onto it makes no progress
        halt_slot = 6;
        bus.resume = 1'b1; tick(); bus.resume = 1'b0;
        wait_state(4, 20, "hlt_wait");
        chk("hlt_cause",   64'(bus.halt_cause), 64'd3);
        chk("hlt_pc",      pc,                  64'h18);
        chk("hlt_retired", 64'(bus.retired),    64'd22);
        bus.step = 1'b1; tick(); bus.step = 1'b0; tick();
        chk("hltstep_state",   64'(bus.state),      64'd4);
        chk("hltstep_cause",   64'(bus.halt_cause), 64'd3);
        chk("hltstep_retired", 64'(bus.retired),    64'd22);
        halt_slot = -1;
        bus.step = 1'b1; tick(); bus.step = 1'b0; tick();
        chk("step2_cause",   64'(bus.halt_cause), 64'd5);
        chk("step2_retired", 64'(bus.retired),    64'd23);

        // stop coinciding with a breakpoint hit
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        n = 0;
        while (!(bus.state == 3'd2 && pc == 64'h10) && n < 30) begin tick(); n++; end
        chk("stopbp_reach", pc, 64'h10);
        bus.stop = 1'b1; tick(); bus.stop = 1'b0;
        chk("stopbp_state", 64'(bus.state),      64'd4);
        chk("stopbp_cause", 64'(bus.halt_cause), 64'd1);

        // start while paused
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        chk("restart_state",   64'(bus.state),   64'd1);
        chk("restart_retired", 64'(bus.retired), 64'd0);

        // randomized phase, checked by the model every cycle
        for (int c = 0; c < 4000; c++) begin
            bus.start  = ($urandom_range(199) == 0);
            bus.stop   = ($urandom_range(39) == 0);
            bus.step   = ($urandom_range(7) == 0);
            bus.resume = ($urandom_range(14) == 0);
            if ($urandom_range(49) == 0) begin
                bus.bp_en   = $urandom_range(1);
                bus.bp_addr = 64'($urandom_range(15)) << 2;
            end
            if ($urandom_range(99) == 0)
                halt_slot = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(15));
            rst = ($urandom_range(599) == 0);
            tick();
        end
        bus.start = 1'b0; bus.stop = 1'b0; bus.step = 1'b0; bus.resume = 1'b0;
        rst = 1'b0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/core_run_ctrl.md
# core_run_ctrl

Run controller for the single-cycle 64-bit datapath. It sequences the core through reset, free-run, single-step and halt. It drives the core's reset and a clock-enable that gates every architectural state update (PC, register file write, data memory write), and it halts on a breakpoint PC match, a halt instruction, a cycle limit or a host stop. It sits between the host/debug logic and the datapath top, observing the current instruction address and instruction word.

## Interface
Parameters:
- RST_CYCLES, 4: cycles core_rst is held in RESET state (≥1).
- MAX_CYCLES, 0: retire limit in RUN; 0 = unlimited.
- HALT_INSN, 32'hD4400000: instruction encoding treated as halt.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  pulse; (re)start program from reset.
- stop  in  1  pulse; pause a running core.
- step  in  1  pulse; execute exactly one instruction while paused.
- resume  in  1  pulse; continue free-run from paused.
- bp_en  in  1  breakpoint enable.
- bp_addr  in  64  breakpoint instruction address.
- ins_Addr  in  64  current PC from datapath.
- ins  in  32  current instruction from instruction memory.
- core_rst  out  1  reset to datapath (PC, register file, data memory).
- core_ce  out  1  clock-enable for all datapath state; combinational from state and halt checks.
- state  out  3  IDLE=0, RESET=1, RUN=2, STEP=3, PAUSED=4.
- halt_cause  out  3  NONE=0, STOP=1, BKPT=2, HLT=3, LIMIT=4, STEP=5.
- retired  out  32  count of cycles with core_ce=1 since last RESET entry; saturates at all-ones.

## Operation
- IDLE: core_rst=1, core_ce=0. start → RESET.
- RESET: core_rst=1, core_ce=0. A down-counter loads RST_CYCLES-1 on entry, and retired clears on entry. When the counter hits 0 → RUN, with halt_cause=NONE.
- RUN: core_rst=0, core_ce=1 unless a halt condition holds this cycle. Halt conditions, evaluated in priority order on current inputs:
  1. stop.
  2. ins==HALT_INSN.
  3. bp_en && ins_Addr==bp_addr && !skip_bp.
  4. MAX_CYCLES≠0 && retired==MAX_CYCLES.
- On a halt condition: core_ce=0 that cycle, so the instruction at the PC is not executed. Next state is PAUSED and halt_cause gets the winning cause.
- skip_bp: set on the transition into RUN or STEP from PAUSED, and cleared after the first cycle in RUN. It lets a resume or step leave a breakpoint PC.
- PAUSED: core_rst=0, core_ce=0. Inputs are handled as follows:
  - step → STEP.
  - resume → RUN.
  - stop is ignored.
- STEP: one cycle.
  - If ins==HALT_INSN: core_ce=0, → PAUSED with cause HLT.
  - Otherwise: core_ce=1, → PAUSED with cause STEP. The breakpoint is ignored.
  - The cycle limit is not checked in STEP.
- start in any state (including RUN/STEP/PAUSED) → RESET next cycle. start has priority over every other input. core_ce=0 in the cycle start is seen.
- Simultaneous pulses in PAUSED: start > step > resume.
- retired increments on every cycle with core_ce=1.

## Timing
- Reset (rst=1) values: state=IDLE, core_rst=1, core_ce=0, halt_cause=NONE, retired=0, skip_bp=0, reset counter=0.
- start at edge k: state=RESET from k+1. core_rst stays high for RST_CYCLES cycles. First core_ce=1 is in cycle k+1+RST_CYCLES.
- Halt detection is zero-latency: core_ce drops in the same cycle the condition appears. state/halt_cause update at the next edge.
- Step: the edge after step samples state=STEP. Exactly one core_ce=1 cycle follows, then PAUSED.
- Pulses are single-cycle. A level held high acts as repeated pulses: repeated start keeps RESET restarting, and a held step steps every other cycle.
- rst mid-run returns to IDLE on the next edge regardless of state.

## Structure
- A shared package holds state encodings, halt_cause encodings and the HALT_INSN default.
- The natural sub-module is core_halt_detect: a combinational priority evaluation of stop/HLT/BKPT/LIMIT returning halt and cause.
- FSM, reset counter, retired counter and skip_bp flag live in core_run_ctrl.

## Test plan
- rst, then start with RST_CYCLES=4 → core_rst high for exactly 4 cycles after RESET entry; then RUN, core_ce=1, retired counts 1,2,3…
- RUN with bp_en=1, bp_addr=0x10, PC reaching 0x10 → core_ce=0 in that cycle; next state PAUSED, halt_cause=2, PC held at 0x10.
- Resume from bp at 0x10 → instruction at 0x10 executes (PC advances). A later revisit of 0x10 halts again with cause 2.
- ins=32'hD4400000 in RUN → core_ce=0, PAUSED, cause 3. Step on that PC → remains PAUSED, cause 3, retired unchanged.
- MAX_CYCLES=5, start → exactly 5 core_ce cycles, then PAUSED with cause 4 and retired=5. step → retired=6, cause 5.
- stop and a breakpoint hit in the same RUN cycle → cause 1. start while PAUSED → RESET next cycle and retired=0.
